ibex_bus_sram_resp: RTL and testbench

//  Responder (slave) end of the Ibex req/gnt/rvalid data/instruction bus.

---
 rtl/ibex_bus_sram_resp.sv | 96 +++++++++
 tb/tb_ibex_bus_sram_resp.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_bus_sram_resp.sv
// Ibex req/gnt/rvalid responder backed by a word-organised SRAM model.
// Fixed read latency, byte-enable writes, bounded outstanding requests.
module ibex_bus_sram_resp #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] WIN = 33'(4 * MEM_WORDS);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [31:0]           mem [MEM_WORDS];
  logic [CW-1:0]         cnt_q;
  logic [32:0]           off;
  logic                  hit;
  logic [AW-1:0]         idx;
  logic                  wr_en;
  logic [31:0]           rd_word;
  logic [RD_LATENCY-1:0] pv_q;
  logic [RD_LATENCY-1:0] pe_q;
  logic [31:0]           pd_q [RD_LATENCY];

  // 33-bit offset: an address below the base wraps high and misses.
  assign off   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign hit   = off < WIN;
  assign idx   = off[AW+1:2];

  assign gnt_o = req_i & ~rst_i & (cnt_q < MAX_CNT);
  assign wr_en = gnt_o & we_i & hit;

  assign rd_word = (gnt_o & ~we_i & hit) ? mem[idx] : 32'h0;

  assign rvalid_o = pv_q[RD_LATENCY-1];
  assign rdata_o  = pd_q[RD_LATENCY-1];
  assign err_o    = pe_q[RD_LATENCY-1];

  // Byte-masked memory update at the grant edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response shift pipeline; data is zero whenever the slot is empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pd_q[i] <= 32'h0;
      end
    end else begin
      pv_q[0] <= gnt_o;
      pe_q[0] <= gnt_o & ~hit;
      pd_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  // Outstanding count: up on grant, down on each response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({gnt_o, rvalid_o})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_bus_sram_resp.sv
// Bench for ibex_bus_sram_resp: vector table, scoreboard and
// multi-cycle sequences on two configurations (LAT 1 and LAT 3).
module tb_ibex_bus_sram_resp;

  logic        clk;
  logic        rst;
  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int outs [2];

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [31:0] mdl [2][64];

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vt[16];

  ibex_bus_sram_resp #(
    .MEM_WORDS(64), .BASE_ADDR(32'h0),
    .RD_LATENCY(1), .MAX_OUTSTANDING(2)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
    .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0])
  );

  ibex_bus_sram_resp #(
    .MEM_WORDS(16), .BASE_ADDR(32'h1000),
    .RD_LATENCY(3), .MAX_OUTSTANDING(2)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
    .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int s);
    return (s == 0) ? 32'h0 : 32'h1000;
  endfunction

  function automatic int words_of(input int s);
    return (s == 0) ? 64 : 16;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int s);
    exp_t x;
    exp_t y;
    logic [32:0] off;
    logic hit;
    int idx;
    check($sformatf("gnt_rule%0d", s), {31'b0, gnt[s]},
          {31'b0, req[s] && outs[s] < 2});
    if (gnt[s]) begin
      off = {1'b0, addr[s]} - {1'b0, base_of(s)};
      hit = off < 33'(4 * words_of(s));
      idx = int'(off[31:2]);
      x.c = cyc + lat_of(s);
      x.e = !hit;
      x.d = 32'h0;
      if (hit) begin
        if (we[s]) begin
          for (int b = 0; b < 4; b++) begin
            if (be[s][b]) mdl[s][idx][8*b +: 8] = wdata[s][8*b +: 8];
          end
        end else begin
          x.d = mdl[s][idx];
        end
      end
      if (s == 0) sb0.push_back(x);
      else sb1.push_back(x);
    end
    if (rvalid[s]) begin
      if ((s == 0 && sb0.size() == 0) || (s == 1 && sb1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL spurious_rvalid%0d actual=1 expected=0 t=%0t",
                 s, $time);
      end else begin
        y = (s == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("sb_rdata%0d", s), rdata[s], y.d);
        check($sformatf("sb_err%0d", s), {31'b0, err[s]}, {31'b0, y.e});
        check($sformatf("sb_latency%0d", s), cyc, y.c);
      end
    end else begin
      check($sformatf("idle_rdata%0d", s), rdata[s], 32'h0);
      check($sformatf("idle_err%0d", s), {31'b0, err[s]}, 32'h0);
    end
    outs[s] = outs[s] + (gnt[s] ? 1 : 0) - (rvalid[s] ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb0.delete();
      sb1.delete();
      outs[0] = 0;
      outs[1] = 0;
    end else begin
      mon(0);
      mon(1);
    end
  end

  task automatic do_txn(input int s, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e,
                        output bit ok);
    int t;
    ok = 0;
    rd = 32'h0;
    e = 1'b0;
    @(posedge clk);
    #1;
    req[s] = 1'b1;
    we[s] = w;
    be[s] = b;
    addr[s] = a;
    wdata[s] = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt[s] && t < 10);
    if (!gnt[s]) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout%0d actual=0 expected=1", s);
      @(posedge clk);
      #1;
      req[s] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req[s] = 1'b0;
    t = 0;
    while (t < 10) begin
      @(negedge clk);
      if (rvalid[s]) begin
        rd = rdata[s];
        e = err[s];
        ok = 1;
        break;
      end
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rvalid_timeout%0d actual=0 expected=1", s);
    end
  endtask

  task automatic stream(input int s, input int n, input logic [31:0] a0,
                        input int ncyc, output logic [15:0] gp,
                        output logic [15:0] rp);
    int g;
    g = 0;
    gp = '0;
    rp = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      req[s] = (g < n);
      we[s] = 1'b0;
      be[s] = 4'hF;
      addr[s] = a0 + 32'(4 * g);
      @(negedge clk);
      gp[k] = gnt[s];
      rp[k] = rvalid[s];
      if (gnt[s]) g++;
    end
    @(posedge clk);
    #1;
    req[s] = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s_gnt%0d", nm, s), {31'b0, gnt[s]}, 32'h0);
      check($sformatf("%s_rvalid%0d", nm, s), {31'b0, rvalid[s]}, 32'h0);
      check($sformatf("%s_rdata%0d", nm, s), rdata[s], 32'h0);
      check($sformatf("%s_err%0d", nm, s), {31'b0, err[s]}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic e;
    bit ok;
    logic [15:0] gp;
    logic [15:0] rp;

    vt[0]  = '{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 1'b0};
    vt[5]  = '{1'b1, 4'hF, 32'h0, 32'h0BADF00D, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 4'hF, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 4'hF, 32'h100, 32'h0, 32'h0, 1'b1};
    vt[8]  = '{1'b1, 4'hF, 32'h100, 32'h12345678, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 4'hF, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0};
    vt[10] = '{1'b0, 4'hF, 32'h0, 32'h0, 32'h0BADF00D, 1'b0};
    vt[11] = '{1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0};
    vt[12] = '{1'b0, 4'hF, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[13] = '{1'b1, 4'hA, 32'h10, 32'h55667788, 32'h0, 1'b0};
    vt[14] = '{1'b0, 4'hF, 32'h10, 32'h0, 32'h55AD77EF, 1'b0};
    vt[15] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1};

    rst = 1'b1;
    outs[0] = 0;
    outs[1] = 0;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0;
      we[s] = 1'b0;
      be[s] = 4'h0;
      addr[s] = 32'h0;
      wdata[s] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    req[0] = 1'b1;
    req[1] = 1'b1;
    addr[1] = 32'h1000;
    #1;
    check_zero("reset");
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_txn(0, vt[i].we, vt[i].be, vt[i].addr, vt[i].wd, rd, e, ok);
      if (ok) begin
        check($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
        check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vt[i].er});
      end
    end

    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1'b1, 4'hF, 32'h1000 + 32'(4 * i),
             32'hB0000000 + 32'(i), rd, e, ok);
      if (ok) check($sformatf("b_wr%0d_err", i), {31'b0, e}, 32'h0);
    end
    do_txn(1, 1'b0, 4'hF, 32'h0FFC, 32'h0, rd, e, ok);
    if (ok) check("b_below_err", {31'b0, e}, 32'h1);
    do_txn(1, 1'b0, 4'hF, 32'h1040, 32'h0, rd, e, ok);
    if (ok) check("b_above_err", {31'b0, e}, 32'h1);
    do_txn(1, 1'b0, 4'hF, 32'h100C, 32'h0, rd, e, ok);
    if (ok) check("b_last_rdata", rd, 32'hB0000003);

    do_txn(0, 1'b1, 4'hF, 32'h4, 32'h11111111, rd, e, ok);
    do_txn(0, 1'b1, 4'hF, 32'h8, 32'h22222222, rd, e, ok);
    stream(0, 3, 32'h0, 5, gp, rp);
    check("a_b2b_gnt", {16'h0, gp}, 32'h0007);
    check("a_b2b_rvalid", {16'h0, rp}, 32'h000E);

    stream(1, 4, 32'h1000, 10, gp, rp);
    check("b_stream_gnt", {16'h0, gp}, 32'h0033);
    check("b_stream_rvalid", {16'h0, rp}, 32'h0198);

    stream(1, 2, 32'h1000, 3, gp, rp);
    check("b_pre_rst_gnt", {16'h0, gp}, 32'h0003);
    check("b_pre_rst_rvalid", {31'b0, rvalid[1]}, 32'h1);
    check("b_pre_rst_rdata", rdata[1], 32'hB0000000);
    rst = 1'b1;
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[0] = 32'h10;
    req[1] = 1'b1;
    addr[1] = 32'h1000;
    #1;
    check_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (8) @(posedge clk);

    stream(1, 4, 32'h1000, 10, gp, rp);
    check("b_post_rst_gnt", {16'h0, gp}, 32'h0033);
    check("b_post_rst_rvalid", {16'h0, rp}, 32'h0198);

    repeat (6) @(posedge clk);
    check("sb_drain_a", 32'(sb0.size()), 32'h0);
    check("sb_drain_b", 32'(sb1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
